psum_collector: RTL and testbench
=================================

PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 SHALL have parameter N_BUSLINE, default 62, the number of reduction-bus lanes.
REQ-002 SHALL have parameter DW_DATA, default 8, the signed width of one bus lane.
REQ-003 SHALL have parameter DW_ACC, default 24, the signed accumulator and output width.
REQ-004 SHALL have parameter IDX_W, default $clog2(N_BUSLINE), the lane-index width.
REQ-005 SHALL have clk  input  1  the single clock; all state is on its rising edge.
REQ-006 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have enable  input  1  input-side enable.
REQ-008 SHALL have in_bus  input  N_BUSLINE*DW_DATA  the partial-sum lanes; lane i is at [i*DW_DATA +: DW_DATA], two's complement.
REQ-009 SHALL have in_valid  input  N_BUSLINE  the per-lane valid mask.
REQ-010 SHALL have in_last  input  1  marks the final beat of an accumulation group.
REQ-011 SHALL have in_ready  output  1  the collector accepts a beat.
REQ-012 SHALL have out_data  output  DW_ACC  the accumulated lane value.
REQ-013 SHALL have out_idx  output  IDX_W  the lane index of out_data.
REQ-014 SHALL have out_valid  output  1  out_data/out_idx are valid.
REQ-015 SHALL have out_ready  input  1  the downstream sink accepts.
REQ-016 SHALL have out_last  output  1  this output is the final one of the group.
REQ-017 SHALL have busy  output  1  the state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, ACCUM and DRAIN, with per-lane registers acc[i] (DW_ACC bits) and hit[i] (1 bit).
REQ-019 in_ready SHALL equal enable AND (state != DRAIN).
REQ-020 A beat SHALL be accepted on a rising edge when in_ready=1 AND (|in_valid OR in_last); all other cycles SHALL leave acc, hit and state unchanged, except for the drain activity in REQ-024 to REQ-026.
REQ-021 On an accepted beat, each lane with in_valid[i]=1 SHALL update acc[i] to acc[i] + sign-extended lane i, wrapping modulo 2^DW_ACC with no saturation, and SHALL set hit[i]=1; other lanes SHALL hold.
REQ-022 State transitions on an accepted beat SHALL be:
  - IDLE to ACCUM when in_last=0.
  - IDLE or ACCUM to DRAIN when in_last=1.
  - The in_last beat's data SHALL be accumulated before the drain.
REQ-023 The first DRAIN cycle SHALL be the cycle after the accepted in_last beat, giving a latency of 1 cycle to out_valid.
REQ-024 In DRAIN, out_valid SHALL be 1 whenever any hit[i]=1; out_idx SHALL be the lowest i with hit[i]=1; out_data SHALL be acc[out_idx].
REQ-025 out_last SHALL be 1 when the presented lane is the only remaining hit lane, and SHALL be 0 otherwise and outside DRAIN.
REQ-026 On out_valid AND out_ready, the collector SHALL clear hit[out_idx] and acc[out_idx] to 0, then present the next hit lane in the following cycle; it SHALL produce at most one output per cycle.
REQ-027 While out_valid=1 AND out_ready=0, out_data, out_idx and out_last SHALL hold stable.
REQ-028 The drain SHALL NOT depend on enable.
REQ-029 After the handshake with out_last=1, the state SHALL move to IDLE in the next cycle.
REQ-030 A DRAIN entered with zero hit lanes (an in_last-only beat with no prior hits) SHALL keep out_valid=0 and SHALL return to IDLE after one cycle.
REQ-031 When out_valid=0, out_data and out_idx SHALL be 0.
REQ-032 busy SHALL equal (state != IDLE).

Reset
REQ-033 Asserting reset low SHALL immediately force:
  - state=IDLE;
  - all acc=0 and all hit=0;
  - out_valid=0, out_last=0, out_data=0, out_idx=0, busy=0, and in_ready=0 while reset is low.
REQ-034 A reset during ACCUM or DRAIN SHALL discard the group with no further outputs; after release the block SHALL behave as freshly reset.

Verification
REQ-035 With N_BUSLINE=4 and DW_DATA=8, the bench SHALL cover this group accumulation:
  - stimulus: beat1 with in_valid=4'b1001, lane0=5, lane3=-2; beat2 with in_valid=4'b0001, lane0=7, in_last=1; out_ready=1.
  - response: (idx0, 12, last=0) then (idx3, -2, last=1), with out_valid first high 1 cycle after beat2, then busy=0.
REQ-036 The bench SHALL cover backpressure:
  - stimulus: same group as REQ-035, with out_ready held 0 for 3 cycles.
  - response: out_idx=0 and out_data=12 held stable, in_ready=0 throughout DRAIN, and no data loss.
REQ-037 The bench SHALL cover accumulator wrap:
  - stimulus: DW_ACC=8, lane1=127 then lane1=1 with in_last.
  - response: output is (idx1, -128).
REQ-038 The bench SHALL cover an empty group:
  - stimulus: in_last=1 with in_valid=0 from IDLE.
  - response: one DRAIN cycle, out_valid never 1, then IDLE.
REQ-039 The bench SHALL cover enable gating:
  - stimulus: enable=0 with in_valid=all ones.
  - response: in_ready=0 and acc unchanged.
REQ-040 The bench SHALL cover reset mid-drain:
  - stimulus: reset low asynchronously during the second output.
  - response: out_valid=0 immediately, all acc=0 after release, and a following group accumulates from 0.

Source files
------------

// File: rtl/psum_collector.sv
// psum_collector: per-lane accumulation of partial sums from a wide
// reduction bus, then serial drain of every touched lane, lowest index first.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no group open; lanes idle, waiting for the first beat
// ST_ACCUM | group open; accepted beats add into the per-lane registers
// ST_DRAIN | group closed; hit lanes presented one per handshake

module psum_collector #(
    parameter int N_BUSLINE = 62,
    parameter int DW_DATA   = 8,
    parameter int DW_ACC    = 24,
    parameter int IDX_W     = $clog2(N_BUSLINE)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [N_BUSLINE*DW_DATA-1:0]   in_bus,
    input  logic [N_BUSLINE-1:0]           in_valid,
    input  logic                           in_last,
    output logic                           in_ready,
    output logic [DW_ACC-1:0]              out_data,
    output logic [IDX_W-1:0]               out_idx,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DW_ACC-1:0]      acc_q [N_BUSLINE];
    logic [DW_ACC-1:0]      acc_d [N_BUSLINE];
    logic [N_BUSLINE-1:0]   hit_q, hit_d;

    logic [N_BUSLINE-1:0]   sel_oh;
    logic [IDX_W-1:0]       sel_idx;
    logic [DW_ACC-1:0]      sel_data;
    logic                   sel_found;
    logic                   beat_acc;

    // Handshake-side flags; in_ready is also held low while reset is asserted.
    always_comb begin
        in_ready = enable & reset & (state_q != ST_DRAIN);
        beat_acc = in_ready & ((|in_valid) | in_last);
        busy     = (state_q != ST_IDLE);
    end

    // Lowest-index hit lane: one-hot select, binary index and its accumulator.
    always_comb begin
        sel_oh    = '0;
        sel_idx   = '0;
        sel_data  = '0;
        sel_found = 1'b0;
        for (int i = 0; i < N_BUSLINE; i++) begin
            if (hit_q[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_oh[i] = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_data  = acc_q[i];
            end
        end
    end

    // Output view is purely a function of registered state, so it is stable
    // under backpressure and zeroed whenever nothing is being presented.
    always_comb begin
        out_valid = (state_q == ST_DRAIN) & sel_found;
        out_idx   = out_valid ? sel_idx  : '0;
        out_data  = out_valid ? sel_data : '0;
        out_last  = out_valid & ~(|(hit_q & ~sel_oh));
    end

    // Next-state, accumulate on accepted beats, clear lanes as they drain.
    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (beat_acc) begin
                    for (int i = 0; i < N_BUSLINE; i++) begin
                        if (in_valid[i]) begin
                            acc_d[i] = acc_q[i]
                                     + DW_ACC'(signed'(in_bus[i*DW_DATA +: DW_DATA]));
                            hit_d[i] = 1'b1;
                        end
                    end
                    state_d = in_last ? ST_DRAIN : ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                if (!out_valid) begin
                    // Empty group: nothing to present, leave after one cycle.
                    state_d = ST_IDLE;
                end else if (out_ready) begin
                    for (int i = 0; i < N_BUSLINE; i++) begin
                        if (sel_oh[i]) begin
                            hit_d[i] = 1'b0;
                            acc_d[i] = '0;
                        end
                    end
                    if (out_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, hit mask and accumulators; async clear discards any open group.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            hit_q   <= '0;
            for (int i = 0; i < N_BUSLINE; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            for (int i = 0; i < N_BUSLINE; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: two instances share stimulus, one with
// a 24-bit accumulator and one with an 8-bit accumulator for the wrap case.

module tb_psum_collector;

    localparam int NB = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic              clk;
    logic              reset;
    logic              enable;
    logic [NB*DW-1:0]  in_bus;
    logic [NB-1:0]     in_valid;
    logic              in_last;
    logic              out_ready;

    logic              a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [23:0]       a_out_data;
    logic [IW-1:0]     a_out_idx;

    logic              w_in_ready, w_out_valid, w_out_last, w_busy;
    logic [7:0]        w_out_data;
    logic [IW-1:0]     w_out_idx;

    int total;
    int bad;

    psum_collector #(.N_BUSLINE(NB), .DW_DATA(DW), .DW_ACC(24), .IDX_W(IW)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .in_bus(in_bus),
        .in_valid(in_valid), .in_last(in_last), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_idx(a_out_idx), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_last(a_out_last), .busy(a_busy)
    );

    psum_collector #(.N_BUSLINE(NB), .DW_DATA(DW), .DW_ACC(8), .IDX_W(IW)) dut_w (
        .clk(clk), .reset(reset), .enable(enable), .in_bus(in_bus),
        .in_valid(in_valid), .in_last(in_last), .in_ready(w_in_ready),
        .out_data(w_out_data), .out_idx(w_out_idx), .out_valid(w_out_valid),
        .out_ready(out_ready), .out_last(w_out_last), .busy(w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NB-1:0] v, input logic [7:0] l3, input logic [7:0] l2,
                         input logic [7:0] l1, input logic [7:0] l0, input logic last);
        in_valid = v;
        in_bus   = {l3, l2, l1, l0};
        in_last  = last;
    endtask

    task automatic idle_in();
        in_valid = '0;
        in_bus   = '0;
        in_last  = 1'b0;
    endtask

    // Checks the 24-bit instance's presented output.
    task automatic chk_out(input string tag, input logic v, input logic [IW-1:0] idx,
                           input logic [23:0] d, input logic last);
        chk({tag, "_valid"}, {31'd0, a_out_valid}, {31'd0, v});
        chk({tag, "_idx"},   {30'd0, a_out_idx},   {30'd0, idx});
        chk({tag, "_data"},  {8'd0, a_out_data},   {8'd0, d});
        chk({tag, "_last"},  {31'd0, a_out_last},  {31'd0, last});
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        enable    = 1'b1;
        out_ready = 1'b1;
        idle_in();

        // Reset state
        #3;
        chk("rst_busy",     {31'd0, a_busy},      32'd0);
        chk("rst_in_ready", {31'd0, a_in_ready},  32'd0);
        chk_out("rst", 1'b0, 2'd0, 24'd0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, a_in_ready}, 32'd1);

        // Basic group: lanes 0 and 3, then lane 0 with last
        drive(4'b1001, 8'hFE, 8'd0, 8'd0, 8'd5, 1'b0);
        tick();
        chk("g1_busy", {31'd0, a_busy}, 32'd1);
        chk_out("g1_accum", 1'b0, 2'd0, 24'd0, 1'b0);
        drive(4'b0001, 8'd0, 8'd0, 8'd0, 8'd7, 1'b1);
        tick();
        idle_in();
        #1;
        chk_out("g1_out0", 1'b1, 2'd0, 24'd12, 1'b0);
        chk("g1_in_ready_drain", {31'd0, a_in_ready}, 32'd0);
        tick();
        chk_out("g1_out1", 1'b1, 2'd3, 24'hFFFFFE, 1'b1);
        tick();
        chk("g1_busy_end", {31'd0, a_busy}, 32'd0);
        chk_out("g1_end", 1'b0, 2'd0, 24'd0, 1'b0);

        // Backpressure: same group, sink stalls three cycles
        out_ready = 1'b0;
        drive(4'b1001, 8'hFE, 8'd0, 8'd0, 8'd5, 1'b0);
        tick();
        drive(4'b0001, 8'd0, 8'd0, 8'd0, 8'd7, 1'b1);
        tick();
        idle_in();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_out("bp_hold", 1'b1, 2'd0, 24'd12, 1'b0);
            chk("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk_out("bp_rel0", 1'b1, 2'd0, 24'd12, 1'b0);
        tick();
        chk_out("bp_rel1", 1'b1, 2'd3, 24'hFFFFFE, 1'b1);
        chk("bp_in_ready_last", {31'd0, a_in_ready}, 32'd0);
        tick();
        chk("bp_busy_end", {31'd0, a_busy}, 32'd0);

        // Accumulator wrap on the 8-bit instance: 127 + 1
        drive(4'b0010, 8'd0, 8'd0, 8'd127, 8'd0, 1'b0);
        tick();
        drive(4'b0010, 8'd0, 8'd0, 8'd1, 8'd0, 1'b1);
        tick();
        idle_in();
        #1;
        chk("wrap_valid", {31'd0, w_out_valid}, 32'd1);
        chk("wrap_idx",   {30'd0, w_out_idx},   32'd1);
        chk("wrap_data",  {24'd0, w_out_data},  32'h80);
        chk("wrap_last",  {31'd0, w_out_last},  32'd1);
        chk_out("wide_nowrap", 1'b1, 2'd1, 24'd128, 1'b1);
        tick();
        chk("wrap_busy_end", {31'd0, w_busy}, 32'd0);

        // Empty group: in_last alone
        drive(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        tick();
        idle_in();
        #1;
        chk("empty_busy", {31'd0, a_busy}, 32'd1);
        chk_out("empty_drain", 1'b0, 2'd0, 24'd0, 1'b0);
        tick();
        chk("empty_busy_end", {31'd0, a_busy}, 32'd0);
        chk("empty_valid_end", {31'd0, a_out_valid}, 32'd0);

        // Enable gating: full-valid beats with enable low are ignored
        enable = 1'b0;
        drive(4'b1111, 8'd9, 8'd9, 8'd9, 8'd9, 1'b1);
        #1;
        chk("en_in_ready", {31'd0, a_in_ready}, 32'd0);
        tick();
        tick();
        chk("en_busy", {31'd0, a_busy}, 32'd0);
        chk("en_valid", {31'd0, a_out_valid}, 32'd0);
        enable = 1'b1;
        drive(4'b0100, 8'd0, 8'd3, 8'd0, 8'd0, 1'b1);
        tick();
        idle_in();
        #1;
        chk_out("en_after", 1'b1, 2'd2, 24'd3, 1'b1);
        tick();
        chk("en_busy_end", {31'd0, a_busy}, 32'd0);

        // Reset during the second output of a drain
        drive(4'b0011, 8'd0, 8'd0, 8'd2, 8'd1, 1'b1);
        tick();
        idle_in();
        #1;
        chk_out("rd_out0", 1'b1, 2'd0, 24'd1, 1'b0);
        tick();
        chk_out("rd_out1", 1'b1, 2'd1, 24'd2, 1'b1);
        reset = 1'b0;
        #1;
        chk_out("rd_async", 1'b0, 2'd0, 24'd0, 1'b0);
        chk("rd_busy", {31'd0, a_busy}, 32'd0);
        chk("rd_in_ready", {31'd0, a_in_ready}, 32'd0);
        tick();
        reset = 1'b1;
        drive(4'b0011, 8'd0, 8'd0, 8'd5, 8'd4, 1'b1);
        tick();
        idle_in();
        #1;
        chk_out("rd_new0", 1'b1, 2'd0, 24'd4, 1'b0);
        tick();
        chk_out("rd_new1", 1'b1, 2'd1, 24'd5, 1'b1);
        tick();
        chk("rd_busy_end", {31'd0, a_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
